punc_mem_responder: RTL and testbench
=====================================

PUNC_MEM_RESPONDER -- requirements
Module: punc_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the storage depth as 2**ADDR_W words of 16 bits.
REQ-002 SHALL have parameter WAIT_CYC, default 2, range 0..15: wait states inserted before each response.
REQ-003 SHALL have parameters PROT_LO and PROT_HI, defaults 8'h00 and 8'h0F: the write-protected address window, inclusive.
REQ-004 SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port cpu_req, input, 1 bit: processor request, held until cpu_ack.
REQ-007 SHALL have port cpu_we, input, 1 bit: 1 means write, 0 means read.
REQ-008 SHALL have port cpu_addr, input, 16 bits: processor address.
REQ-009 SHALL have port cpu_wdata, input, 16 bits: write data.
REQ-010 SHALL have port cpu_ack, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port cpu_rdata, output, 16 bits: read data.
REQ-012 SHALL have port dbg_req, input, 1 bit: debug read request, held until dbg_ack.
REQ-013 SHALL have port dbg_addr, input, 16 bits: debug address.
REQ-014 SHALL have port dbg_ack, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port dbg_rdata, output, 16 bits: debug read data.
REQ-016 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-017 SHALL have port prot_err, output, 1 bit: protected-write rejection pulse.

Function
REQ-018 SHALL implement states IDLE, WAIT and RESP.
REQ-019 IDLE SHALL sample requests on each edge; cpu_req has priority over dbg_req when both are high.
REQ-020 On accept, SHALL latch the source, address (low ADDR_W bits only; upper bits ignored, so addresses alias/wrap), we and wdata.
REQ-021 On accept, SHALL load the wait counter with WAIT_CYC and go to WAIT; if WAIT_CYC==0, SHALL go directly to RESP.
REQ-022 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter reaches 0.
REQ-023 The ack of the latched source SHALL be high for exactly the one RESP cycle; RESP SHALL then go to IDLE.
REQ-024 Latency SHALL be exactly WAIT_CYC+1 cycles from the sampling edge to the ack cycle.
REQ-025 A write SHALL commit on the edge entering RESP.
REQ-026 Read data SHALL be valid in the ack cycle and held until that port's next ack.
REQ-027 cpu_rdata SHALL NOT change on a write.
REQ-028 A requester holding its req through IDLE after its ack SHALL be treated as a new request.
REQ-029 A request arriving while busy SHALL be ignored until IDLE; the losing request of an arbitration SHALL be served in the next IDLE.
REQ-030 Input changes after accept SHALL NOT affect the transaction in flight.

Reset
REQ-031 On rst, SHALL set state=IDLE, counter=0, cpu_ack=0, dbg_ack=0, cpu_rdata=0, dbg_rdata=0, busy=0 and prot_err=0.
REQ-032 rst SHALL NOT clear storage contents.
REQ-033 rst in WAIT SHALL abort the transaction: no write commit and no ack.
REQ-034 rst SHALL override a simultaneous request.

Configuration
REQ-035 With PUNC_MEM_WPROT_EN defined, a cpu write to a latched address in [PROT_LO,PROT_HI] SHALL NOT commit; cpu_ack SHALL still pulse, and prot_err SHALL pulse in the same cycle.
REQ-036 Without PUNC_MEM_WPROT_EN, all writes SHALL commit and prot_err SHALL be constant 0; PROT_LO and PROT_HI SHALL be unused.

Structure
REQ-037 Shared package punc_mem_pkg SHALL hold the state encoding, the 16-bit word width constant and the source-select encoding.
REQ-038 Storage SHALL be sub-module punc_mem_array: single port, synchronous write, asynchronous read, parameterised by ADDR_W.

Verification
REQ-039 Reset, then cpu write 16'hBEEF to 16'h0040, then cpu read 16'h0040 (WAIT_CYC=2) -> ack 3 cycles after each sampling edge; rdata=16'hBEEF.
REQ-040 cpu_req and dbg_req both high at 16'h0040 -> cpu served first; dbg_ack follows after the next IDLE, with dbg_rdata=16'hBEEF.
REQ-041 Write 16'h1234 to 16'h0140 with ADDR_W=8, then read 16'h0040 -> 16'h1234 (alias).
REQ-042 With the macro, write 16'hFFFF to 16'h0005 -> cpu_ack=1, prot_err=1, and a later read still returns the prior value; without the macro, the read returns 16'hFFFF and prot_err stays 0.
REQ-043 rst in WAIT of a write 16'hAAAA to 16'h0050 -> no ack, busy=0 next cycle, and a later read of 16'h0050 returns the old value.
REQ-044 WAIT_CYC=0, back-to-back cpu reads -> ack one cycle after each sampling edge, with no WAIT cycle.

Source files
------------

// File: rtl/punc_mem_pkg.sv
// Shared types and constants for the punc_mem responder slice.
package punc_mem_pkg;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_DBG = 1'b1
  } src_e;
endpackage

// File: rtl/punc_mem_if.sv
// Processor and debug request/response bundle for punc_mem_responder.
interface punc_mem_if;
  import punc_mem_pkg::*;

  // Handshake: a requester raises req with its address/data and holds it until
  // its ack, which is a single-cycle pulse; rdata is valid in the ack cycle and
  // stays put until that port's next ack. Keeping req high past the ack asks
  // for another transaction.
  logic              cpu_req;
  logic              cpu_we;
  logic [15:0]       cpu_addr;
  logic [15:0]       cpu_wdata;
  logic              cpu_ack;
  logic [WORD_W-1:0] cpu_rdata;
  logic              dbg_req;
  logic [15:0]       dbg_addr;
  logic              dbg_ack;
  logic [WORD_W-1:0] dbg_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr,
    input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr,
    output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata
  );
endinterface

// File: rtl/punc_mem_array.sv
// Single-port word storage: synchronous write, asynchronous read, never reset.
module punc_mem_array
  import punc_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/punc_mem_responder.sv
// Wait-state memory responder arbitrating a cpu port over a read-only debug port.
// Optional write protection of [PROT_LO,PROT_HI] is enabled by PUNC_MEM_WPROT_EN.
module punc_mem_responder
  import punc_mem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2,
  parameter int PROT_LO  = 8'h00,
  parameter int PROT_HI  = 8'h0F
) (
  input  logic   clk,
  input  logic   rst,
  punc_mem_if.slave bus,
  output logic   busy,
  output logic   prot_err,
  output state_e state_o
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  src_e              src_q, src_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic [WORD_W-1:0] mem_rdata;
  logic              enter_resp;
  logic              prot_hit;
  logic              mem_we;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^{bus.cpu_addr[WORD_W-1:ADDR_W], bus.dbg_addr[WORD_W-1:ADDR_W]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req || bus.dbg_req) begin
          if (bus.cpu_req) begin
            src_d   = SRC_CPU;
            addr_d  = bus.cpu_addr[ADDR_W-1:0];
            we_d    = bus.cpu_we;
            wdata_d = bus.cpu_wdata;
          end else begin
            src_d   = SRC_DBG;
            addr_d  = bus.dbg_addr[ADDR_W-1:0];
            we_d    = 1'b0;
          end
          if (WAIT_CYC == 0) begin
            state_d = ST_RESP;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYC);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The *_d view is the transaction in flight, including one accepted this
  // very edge when there are no wait states, so storage is addressed from it.
  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign mem_we     = enter_resp && we_d && !prot_hit && !rst;

`ifdef PUNC_MEM_WPROT_EN
  logic prot_q;

  assign prot_hit = (src_d == SRC_CPU) && we_d &&
                    (int'(addr_d) >= PROT_LO) && (int'(addr_d) <= PROT_HI);

  always_ff @(posedge clk) begin
    if (rst)             prot_q <= 1'b0;
    else if (enter_resp) prot_q <= prot_hit;
  end

  assign prot_err = (state_q == ST_RESP) && prot_q;
`else
  logic unused_prot;

  assign unused_prot = ^{PROT_LO, PROT_HI};
  assign prot_hit    = 1'b0;
  assign prot_err    = 1'b0;
`endif

  punc_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (addr_d),
    .wdata_i (wdata_d),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp && (src_d == SRC_CPU) && !we_d) cpu_rdata_q <= mem_rdata;
      if (enter_resp && (src_d == SRC_DBG))          dbg_rdata_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    src_q   <= src_d;
    addr_q  <= addr_d;
    we_q    <= we_d;
    wdata_q <= wdata_d;
  end

  assign bus.cpu_ack   = (state_q == ST_RESP) && (src_q == SRC_CPU);
  assign bus.dbg_ack   = (state_q == ST_RESP) && (src_q == SRC_DBG);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign busy          = (state_q != ST_IDLE);
  assign state_o       = state_q;
endmodule

// File: tb/tb_punc_mem_responder.sv
// Bench for punc_mem_responder: a WAIT_CYC=2 instance and a WAIT_CYC=0 instance.
`timescale 1ns/1ps
module tb_punc_mem_responder;
  import punc_mem_pkg::*;

  localparam int AW  = 8;
  localparam int PLO = 0;
  localparam int PHI = 15;
`ifdef PUNC_MEM_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  typedef struct {
    logic        cpu_ack;
    logic        dbg_ack;
    logic        busy;
    logic        prot_err;
    logic [15:0] cpu_rdata;
    logic [15:0] dbg_rdata;
  } obs_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic        exp_prot;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst0, rst1;
  logic   busy0, busy1, perr0, perr1;
  state_e st0, st1;

  always #5 clk = ~clk;

  punc_mem_if bus0();
  punc_mem_if bus1();

  punc_mem_responder #(.ADDR_W(AW), .WAIT_CYC(2), .PROT_LO(PLO), .PROT_HI(PHI)) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0), .busy(busy0), .prot_err(perr0), .state_o(st0)
  );

  punc_mem_responder #(.ADDR_W(AW), .WAIT_CYC(0), .PROT_LO(PLO), .PROT_HI(PHI)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1), .busy(busy1), .prot_err(perr1), .state_o(st1)
  );

  // Reference model: plain word arrays per instance, indexed by address mod depth.
  logic [15:0] mdl [2][256];
  bit          mvld [2][256];
  logic [15:0] last_cpu [2];
  logic [15:0] exp_q [$];
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  function automatic obs_t sample(input int d);
    obs_t o;
    if (d == 0) begin
      o.cpu_ack = bus0.cpu_ack; o.dbg_ack = bus0.dbg_ack; o.busy = busy0; o.prot_err = perr0;
      o.cpu_rdata = bus0.cpu_rdata; o.dbg_rdata = bus0.dbg_rdata;
    end else begin
      o.cpu_ack = bus1.cpu_ack; o.dbg_ack = bus1.dbg_ack; o.busy = busy1; o.prot_err = perr1;
      o.cpu_rdata = bus1.cpu_rdata; o.dbg_rdata = bus1.dbg_rdata;
    end
    return o;
  endfunction

  task automatic drive_cpu(input int d, input logic req, input logic we,
                           input logic [15:0] addr, input logic [15:0] wdata);
    if (d == 0) begin
      bus0.cpu_req = req; bus0.cpu_we = we; bus0.cpu_addr = addr; bus0.cpu_wdata = wdata;
    end else begin
      bus1.cpu_req = req; bus1.cpu_we = we; bus1.cpu_addr = addr; bus1.cpu_wdata = wdata;
    end
  endtask

  task automatic drive_dbg(input int d, input logic req, input logic [15:0] addr);
    if (d == 0) begin
      bus0.dbg_req = req; bus0.dbg_addr = addr;
    end else begin
      bus1.dbg_req = req; bus1.dbg_addr = addr;
    end
  endtask

  // Called at a falling edge with the instance idle; returns at a falling edge, idle again.
  task automatic cpu_op(input int d, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rd, output logic perr);
    obs_t o;
    int lat, a;
    logic exp_prot;
    logic [15:0] exp_rd;
    a = int'(addr) % 256;
    lat = 0; rd = '0; perr = 1'b0;
    drive_cpu(d, 1'b1, we, addr, wdata);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      o = sample(d);
      if (o.cpu_ack) begin
        lat = k;
        break;
      end
      drive_cpu(d, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    end
    drive_cpu(d, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("cpu_latency", 16'(lat), 16'(wait_of(d) + 1));
    if (lat != 0) begin
      exp_prot = WPROT && we && (a >= PLO) && (a <= PHI);
      chk1("cpu_prot_err", o.prot_err, exp_prot);
      chk1("cpu_no_dbg_ack", o.dbg_ack, 1'b0);
      rd = o.cpu_rdata; perr = o.prot_err;
      if (we) begin
        chk("cpu_rdata_hold_on_write", o.cpu_rdata, last_cpu[d]);
        if (!exp_prot) begin
          mdl[d][a] = wdata; mvld[d][a] = 1'b1;
        end
      end else if (mvld[d][a]) begin
        exp_q.push_back(mdl[d][a]);
        exp_rd = exp_q.pop_front();
        chk("cpu_rdata", o.cpu_rdata, exp_rd);
        last_cpu[d] = exp_rd;
      end else begin
        // never-written word: its first observation defines it
        mdl[d][a] = o.cpu_rdata; mvld[d][a] = 1'b1; last_cpu[d] = o.cpu_rdata;
      end
    end
    @(negedge clk);
    o = sample(d);
    chk1("cpu_ack_one_cycle", o.cpu_ack, 1'b0);
    chk1("busy_back_to_idle", o.busy, 1'b0);
  endtask

  task automatic dbg_op(input int d, input logic [15:0] addr);
    obs_t o;
    int lat, a;
    a = int'(addr) % 256;
    lat = 0;
    drive_dbg(d, 1'b1, addr);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      o = sample(d);
      if (o.dbg_ack) begin
        lat = k;
        break;
      end
      drive_dbg(d, 1'b1, 16'($urandom));
    end
    drive_dbg(d, 1'b0, 16'h0);
    chk("dbg_latency", 16'(lat), 16'(wait_of(d) + 1));
    if (lat != 0) begin
      chk1("dbg_no_cpu_ack", o.cpu_ack, 1'b0);
      chk1("dbg_prot_err", o.prot_err, 1'b0);
      if (mvld[d][a]) begin
        exp_q.push_back(mdl[d][a]);
        chk("dbg_rdata", o.dbg_rdata, exp_q.pop_front());
      end else begin
        mdl[d][a] = o.dbg_rdata; mvld[d][a] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs [9];
    obs_t        o;
    logic [15:0] rd;
    logic        pe;
    int          lat, acks;

    // Reset with both requests held high: reset must win.
    rst0 = 1'b1; rst1 = 1'b1;
    for (int d = 0; d < 2; d++) begin
      drive_cpu(d, 1'b1, 1'b1, 16'h0040, 16'h5555);
      drive_dbg(d, 1'b1, 16'h0040);
      last_cpu[d] = 16'h0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = sample(d);
      chk1("rst_busy", o.busy, 1'b0);
      chk1("rst_cpu_ack", o.cpu_ack, 1'b0);
      chk1("rst_dbg_ack", o.dbg_ack, 1'b0);
      chk1("rst_prot_err", o.prot_err, 1'b0);
      chk("rst_cpu_rdata", o.cpu_rdata, 16'h0);
      chk("rst_dbg_rdata", o.dbg_rdata, 16'h0);
      drive_cpu(d, 1'b0, 1'b0, 16'h0, 16'h0);
      drive_dbg(d, 1'b0, 16'h0);
    end
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    // Directed table on the two-wait-state instance.
    vecs[0] = '{1'b1, 16'h0040, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 16'h0040, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 16'h0140, 16'h1234, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 16'h0040, 16'h0000, 1'b1, 16'h1234, 1'b0};
    vecs[4] = '{1'b0, 16'h0005, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{1'b1, 16'h0005, 16'hFFFF, 1'b0, 16'h0000, WPROT};
    vecs[6] = '{1'b0, 16'h0005, 16'h0000, !WPROT, 16'hFFFF, 1'b0};
    vecs[7] = '{1'b1, 16'h0040, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
    vecs[8] = '{1'b0, 16'h0140, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
    for (int i = 0; i < 9; i++) begin
      cpu_op(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, pe);
      chk1("vec_prot_err", pe, vecs[i].exp_prot);
      if (vecs[i].chk_rd) chk("vec_rdata", rd, vecs[i].exp_rd);
    end

    // Simultaneous requests: cpu first, debug served from the following idle.
    drive_cpu(0, 1'b1, 1'b0, 16'h0040, 16'h0);
    drive_dbg(0, 1'b1, 16'h0040);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      o = sample(0);
      if (o.cpu_ack) begin lat = k; break; end
    end
    drive_cpu(0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("arb_cpu_latency", 16'(lat), 16'd3);
    chk1("arb_dbg_waits", o.dbg_ack, 1'b0);
    chk("arb_cpu_rdata", o.cpu_rdata, 16'hBEEF);
    last_cpu[0] = 16'hBEEF;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      o = sample(0);
      if (o.dbg_ack) begin lat = k; break; end
    end
    drive_dbg(0, 1'b0, 16'h0);
    chk("arb_dbg_after_idle", 16'(lat), 16'd4);
    chk("arb_dbg_rdata", o.dbg_rdata, 16'hBEEF);
    @(negedge clk);

    // Reset on the would-be commit edge of a write aborts it.
    cpu_op(0, 1'b1, 16'h0050, 16'h1111, rd, pe);
    drive_cpu(0, 1'b1, 1'b1, 16'h0050, 16'hAAAA);
    repeat (2) @(negedge clk);
    chk1("abort_busy_in_wait", busy0, 1'b1);
    rst0 = 1'b1;
    drive_cpu(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    rst0 = 1'b0;
    o = sample(0);
    chk1("abort_busy_cleared", o.busy, 1'b0);
    chk("abort_rdata_cleared", o.cpu_rdata, 16'h0);
    last_cpu[0] = 16'h0;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      acks += int'(bus0.cpu_ack);
    end
    chk("abort_no_ack", 16'(acks), 16'd0);
    cpu_op(0, 1'b0, 16'h0050, 16'h0, rd, pe);
    chk("abort_old_value", rd, 16'h1111);

    // Randomised traffic on both instances against the model.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        logic [15:0] a;
        int op;
        a  = 16'(($urandom_range(0, 255) << 8) | $urandom_range(0, 31));
        op = $urandom_range(0, 2);
        if (op == 2) dbg_op(d, a);
        else cpu_op(d, (op == 0), a, 16'($urandom), rd, pe);
      end
    end

    // Zero-wait instance: a held read repeats every two cycles with no wait state.
    cpu_op(1, 1'b1, 16'h0040, 16'h4444, rd, pe);
    cpu_op(1, 1'b0, 16'h0040, 16'h0, rd, pe);
    chk("zw_read", rd, 16'h4444);
    drive_cpu(1, 1'b1, 1'b0, 16'h0040, 16'h0);
    acks = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk1("zw_hold_ack_pattern", bus1.cpu_ack, logic'(k % 2));
      if (bus1.cpu_ack) begin
        acks++;
        chk("zw_hold_rdata", bus1.cpu_rdata, 16'h4444);
      end
    end
    drive_cpu(1, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("zw_hold_acks", 16'(acks), 16'd3);
    @(negedge clk);
    chk1("zw_idle_after_hold", busy1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
